// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single mfa/mfc handshake RAM; misaligned requests fail without touching RAM.
// Latency: ack 3 cycles after req sample when the RAM completes at once, 2 cycles for a misaligned error, timeout after TIMEOUT waits.
// Backpressure: requesters hold req until their ack; a RAM that keeps mfc high after ack stalls the next grant.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        rw0,
    input  logic [1:0]  size0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        rw1,
    input  logic [1:0]  size1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [31:0] rdata,
    output logic        ram_mfa,
    output logic        ram_rw,
    output logic [1:0]  ram_size,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_mfc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic        last_grant;
    logic        cur_port;
    logic        err_q;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_inc;
    logic        timed_out;
    logic        grant_en;
    logic        sel_port;
    logic        sel_rw;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        sel_port  = (req0 && req1) ? ~last_grant : req1;
        sel_rw    = sel_port ? rw1    : rw0;
        sel_size  = sel_port ? size1  : size0;
        sel_addr  = sel_port ? addr1  : addr0;
        sel_wdata = sel_port ? wdata1 : wdata0;
        case (sel_size)
            2'b00:   sel_bad = 1'b0;
            2'b01:   sel_bad = sel_addr[0];
            2'b10:   sel_bad = |sel_addr[1:0];
            default: sel_bad = 1'b1;
        endcase
    end

    assign wait_cnt_inc = wait_cnt + 8'd1;
    assign timed_out    = (wait_cnt_inc == TIMEOUT_CNT);

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        ram_mfa  = 1'b0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        err      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_en = 1'b1;
                    state_d  = sel_bad ? ACK : ISSUE;
                end
            end
            ISSUE: begin
                ram_mfa = 1'b1;
                if (ram_mfc || timed_out) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                ack0    = ~cur_port;
                ack1    = cur_port;
                err     = err_q;
                state_d = ram_mfc ? RELEASE : IDLE;
            end
            RELEASE: begin
                if (!ram_mfc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt   <= 8'd0;
            ram_rw     <= 1'b1;
            ram_size   <= 2'b00;
            ram_addr   <= 32'd0;
            ram_wdata  <= 32'd0;
            rdata      <= 32'd0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                last_grant <= sel_port;
                cur_port   <= sel_port;
                ram_rw     <= sel_rw;
                ram_size   <= sel_size;
                ram_addr   <= sel_addr;
                ram_wdata  <= sel_wdata;
                err_q      <= sel_bad;
                wait_cnt   <= 8'd0;
            end
            // Completion wins over a timeout landing on the same cycle.
            if (state_q == ISSUE) begin
                if (ram_mfc) begin
                    rdata <= ram_rdata;
                end else begin
                    wait_cnt <= wait_cnt_inc;
                    err_q    <= timed_out;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max ISSUE cycles without ram_mfc before abort (range 1..255).
REQ-002 SHALL have port Clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req0  input  1  port 0 (instruction fetch) request, held until ack0.
REQ-005 SHALL have port rw0  input  1  port 0 direction, 1=read, 0=write.
REQ-006 SHALL have port size0  input  2  port 0 size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 SHALL have port addr0  input  32  port 0 byte address.
REQ-008 SHALL have port wdata0  input  32  port 0 write data.
REQ-009 SHALL have ports req1, rw1, size1, addr1, wdata1  input  1/1/2/32/32  port 1 (load/store), same meaning as port 0.
REQ-010 SHALL have port ack0  output  1  one-cycle completion pulse to port 0.
REQ-011 SHALL have port ack1  output  1  one-cycle completion pulse to port 1.
REQ-012 SHALL have port err  output  1  error flag, valid only while ack0 or ack1 is high.
REQ-013 SHALL have port rdata  output  32  read data, valid only during ack of a read with err=0.
REQ-014 SHALL have port ram_mfa  output  1  memory function active to RAM.
REQ-015 SHALL have port ram_rw  output  1  RAM direction, 1=read.
REQ-016 SHALL have port ram_size  output  2  RAM access size.
REQ-017 SHALL have port ram_addr  output  32  RAM address.
REQ-018 SHALL have port ram_wdata  output  32  RAM write data.
REQ-019 SHALL have port ram_rdata  input  32  RAM read data, valid while ram_mfc=1.
REQ-020 SHALL have port ram_mfc  input  1  memory function complete from RAM.

Function
REQ-021 SHALL implement states IDLE, ISSUE, ACK, RELEASE.
REQ-022 IDLE: if any req high, SHALL select a port, latch its rw/size/addr/wdata into ram_* registers, and update last_grant.
REQ-023 Selection SHALL be round-robin: if only one req is high, grant it; if both are high, grant the port not equal to last_grant.
REQ-024 Misalignment (size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11) SHALL go IDLE->ACK with err=1, never asserting ram_mfa.
REQ-025 Aligned request SHALL go IDLE->ISSUE; ram_mfa=1 throughout ISSUE, starting the cycle after req is sampled.
REQ-026 ISSUE: on sampled ram_mfc=1, SHALL capture ram_rdata into rdata and go to ACK with err=0.
REQ-027 ISSUE: 8-bit wait counter SHALL clear on entry and increment each ISSUE cycle with ram_mfc=0; on reaching TIMEOUT, SHALL go to ACK with err=1.
REQ-028 ACK: ram_mfa=0 and exactly one of ack0/ack1 high for one cycle; next state SHALL be RELEASE if ram_mfc=1, else IDLE.
REQ-029 RELEASE: ram_mfa=0; SHALL remain until ram_mfc=0, then go to IDLE.
REQ-030 Minimum aligned access latency SHALL be 3 cycles from req sample to ack (ram_mfc returned on the first ISSUE cycle).
REQ-031 A req held high in the cycle after its ack SHALL be treated as a new request.
REQ-032 ram_* outputs SHALL remain stable from ISSUE entry to ACK exit; rdata SHALL hold its value until the next capture.
REQ-033 Requester input changes while not in IDLE SHALL be ignored.

Reset
REQ-034 Reset SHALL force state IDLE, last_grant=1 (port 0 wins the first tie), counter=0, ack0=ack1=err=ram_mfa=0, ram_rw=1, ram_size=00, and ram_addr, ram_wdata, rdata=0.
REQ-035 Reset asserted in ISSUE, ACK or RELEASE SHALL abort the access: no ack is issued and ram_mfa=0 after the reset edge.

Verification
REQ-036 req0 word read, addr0=0x10, RAM ram_mfc=1 on 1st ISSUE cycle with ram_rdata=0x9C044012 -> ack0 3 cycles after req, err=0, rdata=0x9C044012.
REQ-037 req0 and req1 both held continuously after reset -> grants alternate 0,1,0,1, with no ack on either port missing.
REQ-038 req1 word write, addr1=0x22 -> ack1 with err=1 two cycles after req; ram_mfa never asserted.
REQ-039 TIMEOUT=15, ram_mfc tied 0 -> ram_mfa high for exactly 15 cycles, then ack with err=1, then IDLE.
REQ-040 ram_mfc held high 4 cycles past ACK -> FSM stays in RELEASE; the next pending req is not granted until ram_mfc=0.
REQ-041 Reset pulsed during ISSUE -> ram_mfa=0 after the reset edge, no ack, and the next tied request is granted to port 0.
